// File: rtl/tdc_pkg.sv
// Shared TDC definitions: default widths and the accumulator's block state.
package tdc_pkg;

   localparam int HW_W_DEF   = 7;
   localparam int MAX_HW_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/tdc_hw_accum_if.sv
// Sample input and block-result handshake between the host side and the accumulator.
interface tdc_hw_accum_if
   import tdc_pkg::*;
#(
   parameter int HW_W         = HW_W_DEF,
   parameter int LOG2_SAMPLES = 4
);
   localparam int SUM_W = HW_W + LOG2_SAMPLES;

   logic             start;
   logic [HW_W-1:0]  hw_in;
   logic             hw_valid;
   logic             res_valid;
   logic             res_ready;
   logic [SUM_W-1:0] res_sum;
   logic [HW_W-1:0]  res_mean;
   logic [HW_W-1:0]  res_min;
   logic [HW_W-1:0]  res_max;
   logic             busy;
   logic             range_err;

   modport master (
      output start, hw_in, hw_valid, res_ready,
      input  res_valid, res_sum, res_mean, res_min, res_max, busy, range_err
   );

   modport slave (
      input  start, hw_in, hw_valid, res_ready,
      output res_valid, res_sum, res_mean, res_min, res_max, busy, range_err
   );

endinterface

// File: rtl/tdc_minmax_reg.sv
// One running extremum (min or max) with clear and update; ext_upd already
// folds in the current sample so the parent can latch it on the final sample.
module tdc_minmax_reg #(
   parameter int W      = 7,
   parameter bit IS_MAX = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         update,
   input  logic [W-1:0] din,
   output logic [W-1:0] ext_upd
);
   localparam logic [W-1:0] INIT = IS_MAX ? {W{1'b0}} : {W{1'b1}};

   logic [W-1:0] ext_r;
   logic         take_s;

   // Decide whether the incoming sample beats the stored extremum
   always_comb begin
      take_s = 1'b0;
      if (IS_MAX) begin
         take_s = (din > ext_r);
      end else begin
         take_s = (din < ext_r);
      end
      ext_upd = take_s ? din : ext_r;
   end

   // Stored extremum, reinitialised at every block start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_r <= INIT;
      end else if (clear) begin
         ext_r <= INIT;
      end else if (update) begin
         ext_r <= ext_upd;
      end else begin
         ext_r <= ext_r;
      end
   end

endmodule

// File: rtl/tdc_hw_accum.sv
// Accumulates a block of 2^LOG2_SAMPLES clamped hamming weights and reports
// sum, mean, min and max through a valid/ready result port.
module tdc_hw_accum
   import tdc_pkg::*;
#(
   parameter int HW_W         = HW_W_DEF,
   parameter int MAX_HW       = MAX_HW_DEF,
   parameter int LOG2_SAMPLES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   tdc_hw_accum_if.slave bus
);
   localparam int SUM_W = HW_W + LOG2_SAMPLES;
   localparam logic [HW_W-1:0]         MAX_HW_V = HW_W'(MAX_HW);
   localparam logic [LOG2_SAMPLES-1:0] CNT_LAST = {LOG2_SAMPLES{1'b1}};
   localparam logic [LOG2_SAMPLES-1:0] CNT_ONE  = LOG2_SAMPLES'(1);

   state_t                  state_r, state_next_s;
   logic [LOG2_SAMPLES-1:0] count_r;
   logic [SUM_W-1:0]        sum_r, sum_upd_s;
   logic [HW_W-1:0]         samp_s, min_upd_s, max_upd_s;
   logic                    over_s, fire_s, clear_s, ack_s, last_s;
   logic [SUM_W-1:0]        res_sum_r;
   logic [HW_W-1:0]         res_mean_r, res_min_r, res_max_r;
   logic                    res_valid_r, busy_r, range_err_r;

   // Clamp the incoming sample and form the running sum including it
   always_comb begin
      over_s    = (bus.hw_in > MAX_HW_V);
      samp_s    = over_s ? MAX_HW_V : bus.hw_in;
      sum_upd_s = sum_r + SUM_W'(samp_s);
   end

   // Next-state and control strobes; a start in ACC discards that cycle's sample
   always_comb begin
      state_next_s = state_r;
      fire_s       = 1'b0;
      clear_s      = 1'b0;
      ack_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (en && bus.start) begin
               state_next_s = ST_ACC;
               clear_s      = 1'b1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ACC: begin
            if (en && bus.start) begin
               state_next_s = ST_ACC;
               clear_s      = 1'b1;
            end else if (en && bus.hw_valid) begin
               fire_s       = 1'b1;
               state_next_s = (count_r == CNT_LAST) ? ST_DONE : ST_ACC;
            end else begin
               state_next_s = ST_ACC;
            end
         end
         ST_DONE: begin
            if (en && bus.res_ready) begin
               ack_s = 1'b1;
               if (bus.start) begin
                  state_next_s = ST_ACC;
                  clear_s      = 1'b1;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end else begin
               state_next_s = ST_DONE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
      last_s = fire_s && (count_r == CNT_LAST);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s == ST_ACC);
      end
   end

   // Sample counter, running sum and sticky clamp flag for the open block
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r     <= {LOG2_SAMPLES{1'b0}};
         sum_r       <= {SUM_W{1'b0}};
         range_err_r <= 1'b0;
      end else if (clear_s) begin
         count_r     <= {LOG2_SAMPLES{1'b0}};
         sum_r       <= {SUM_W{1'b0}};
         range_err_r <= 1'b0;
      end else if (fire_s) begin
         count_r     <= count_r + CNT_ONE;
         sum_r       <= sum_upd_s;
         range_err_r <= range_err_r | over_s;
      end else begin
         count_r     <= count_r;
         sum_r       <= sum_r;
         range_err_r <= range_err_r;
      end
   end

   // Result registers load on the final sample and otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_sum_r   <= {SUM_W{1'b0}};
         res_mean_r  <= {HW_W{1'b0}};
         res_min_r   <= {HW_W{1'b0}};
         res_max_r   <= {HW_W{1'b0}};
         res_valid_r <= 1'b0;
      end else if (last_s) begin
         res_sum_r   <= sum_upd_s;
         res_mean_r  <= sum_upd_s[SUM_W-1:LOG2_SAMPLES];
         res_min_r   <= min_upd_s;
         res_max_r   <= max_upd_s;
         res_valid_r <= 1'b1;
      end else if (ack_s) begin
         res_valid_r <= 1'b0;
      end else begin
         res_valid_r <= res_valid_r;
      end
   end

   tdc_minmax_reg #(.W(HW_W), .IS_MAX(1'b0)) u_min (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear_s),
      .update  (fire_s),
      .din     (samp_s),
      .ext_upd (min_upd_s)
   );

   tdc_minmax_reg #(.W(HW_W), .IS_MAX(1'b1)) u_max (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear_s),
      .update  (fire_s),
      .din     (samp_s),
      .ext_upd (max_upd_s)
   );

   assign bus.res_valid = res_valid_r;
   assign bus.res_sum   = res_sum_r;
   assign bus.res_mean  = res_mean_r;
   assign bus.res_min   = res_min_r;
   assign bus.res_max   = res_max_r;
   assign bus.busy      = busy_r;
   assign bus.range_err = range_err_r;

endmodule

// File: doc/tdc_hw_accum.md
Name: tdc_hw_accum

Overview:
Downstream stage of the TDC top. It consumes the per-measurement hamming-weight word and its valid strobe, and accumulates a block of 2^LOG2_SAMPLES accepted samples. For each block it reports the sum, the mean (sum right-shifted), the minimum and the maximum through a valid/ready result port. The block gives the host averaged, jitter-reduced delay-line readings without sampling every TDC capture.

Parameters:
HW_W, 7, width of hw_in; holds 0..N for a 64-stage line.
MAX_HW, 64, largest legal hamming weight. Larger inputs are clamped and flagged.
LOG2_SAMPLES, 4, log2 of samples per block (16).
SUM_W, HW_W+LOG2_SAMPLES, derived localparam, not overridable.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  global enable; when low, all inputs are ignored and state is frozen
start  in  1  single-cycle request to begin a block
hw_in  in  HW_W  hamming weight from the TDC
hw_valid  in  1  hw_in qualifier; one sample per cycle when high
res_valid  out  1  result registers hold a completed block
res_ready  in  1  consumer accepts the result
res_sum  out  SUM_W  sum of the block's samples (after clamping)
res_mean  out  HW_W  res_sum >> LOG2_SAMPLES (truncating)
res_min  out  HW_W  smallest sample in the block
res_max  out  HW_W  largest sample in the block
busy  out  1  high in ACC
range_err  out  1  sticky; a sample exceeded MAX_HW since the last start

Behaviour:
- Reset (async assert, sync deassert handled upstream) drives:
  - state=IDLE, count=0, accumulator=0;
  - all res_* = 0, res_valid=0, busy=0, range_err=0.
- Sample acceptance: acc_fire = en & hw_valid & (state==ACC).
- Clamping: samp = (hw_in > MAX_HW) ? MAX_HW : hw_in. When clamping occurs on acc_fire, range_err is set.
- IDLE:
  - en & start → ACC.
  - On entry: sum=0, min=all-ones, max=0, count=0, range_err=0.
- ACC:
  - Each acc_fire: sum += samp, min = min(min, samp), max = max(max, samp), count += 1.
  - When acc_fire with count == 2^LOG2_SAMPLES−1 → DONE. In the same edge, res_sum/min/max/mean load the values including that last sample, and res_valid=1 (1-cycle latency from the last sample).
  - en & start in ACC aborts and restarts the block (same clear as on IDLE entry). A sample present that cycle is discarded.
- DONE:
  - Results are held stable and res_valid=1.
  - hw_valid is ignored (samples are dropped, not buffered).
  - en & res_ready & ~start → IDLE, res_valid=0. Result registers keep their last values.
  - en & res_ready & start → ACC directly (back-to-back), res_valid=0, accumulators cleared.
  - start without res_ready: ignored.
- Width: SUM_W is exact for 2^LOG2_SAMPLES samples of at most MAX_HW < 2^HW_W, so the sum cannot overflow.
- en low: no state, counter or result changes in any state. res_valid holds.
- Reset mid-ACC or mid-DONE: partial and pending results are discarded, all outputs return to reset values.

Decomposition:
- Package tdc_pkg:
  - state enum {IDLE, ACC, DONE} as a 2-bit logic typedef;
  - localparam defaults for HW_W and MAX_HW shared with the TDC top.
- Optional sub-module tdc_minmax_reg holds one running extremum, with clear, update and a compare-polarity parameter. It is instantiated twice, for min and max.
- Counter and sum live in the parent.

Test Plan:
- Constant input: start, then 16 samples of hw_in=32 on consecutive cycles → one cycle after the 16th, res_valid=1, res_sum=512, res_mean=32, min=max=32, range_err=0.
- Ramp with gaps: samples 0..15 with hw_valid gapped every other cycle → res_sum=120, res_mean=7, res_min=0, res_max=15. busy drops on the transition to DONE.
- Backpressure:
  - hold res_ready=0 for 10 cycles while driving hw_valid=1 with random data → results unchanged, res_valid stays 1;
  - then raise res_ready and start together → next cycle res_valid=0, busy=1, and a new block accumulates correctly.
- Clamp: a block with one sample of 100 and fifteen of 10 → that sample counts as 64, res_sum=214, res_max=64, range_err=1. The next start clears range_err.
- Abort and enable:
  - 5 samples, then start again, then 16 samples of 1 → res_sum=16;
  - en low for 3 cycles mid-block while hw_valid=1 → those samples are excluded.
- Reset: assert rst_n=0 asynchronously (between clock edges) mid-ACC after 8 samples → outputs go to 0 immediately, state IDLE. A fresh block after release yields correct results.
